// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the hazard control unit: FSM states and the
// NOP control values loaded into pipeline registers when a bubble is inserted.
package hazard_ctrl_unit_pkg;

    typedef enum logic {
        StRun     = 1'b0,
        StMduWait = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [4:0] rd;
    } nop_ctrl_t;

    localparam nop_ctrl_t NopCtrl = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, rd: 5'd0};

    // A load in EX whose rd feeds an ID source operand; x0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module hazard_ctrl_unit_sat_counter
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls, EX redirect flushes and MDU wait
// stalls with a watchdog, plus saturating stall/flush performance counters.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int unsigned MDU_MAX_CYCLES = 40,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_redirect_i,
    input  logic             ex_mdu_op_i,
    input  logic             mdu_done_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_bubble_o,
    output logic             mdu_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [7:0] WdLast = 8'(MDU_MAX_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [7:0] wd_q, wd_d;
    logic       timeout_d;
    logic       load_use;

    assign load_use = load_use_hit(ex_mem_read_i, ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i,
                                   id_uses_rs1_i, id_uses_rs2_i);

    always_comb begin
        state_d         = state_q;
        wd_d            = wd_q;
        timeout_d       = mdu_timeout_o;
        pc_stall_o      = 1'b0;
        if_id_stall_o   = 1'b0;
        if_id_flush_o   = 1'b0;
        id_ex_stall_o   = 1'b0;
        id_ex_bubble_o  = 1'b0;
        ex_mem_bubble_o = 1'b0;
        // Gate on rst_n so outputs fall asynchronously with reset, whatever the inputs.
        if (rst_n) begin
            unique case (state_q)
                StRun: begin
                    if (ex_redirect_i) begin
                        if_id_flush_o  = 1'b1;
                        id_ex_bubble_o = 1'b1;
                    end else if (ex_mdu_op_i && !mdu_done_i) begin
                        pc_stall_o      = 1'b1;
                        if_id_stall_o   = 1'b1;
                        id_ex_stall_o   = 1'b1;
                        ex_mem_bubble_o = 1'b1;
                        state_d         = StMduWait;
                        wd_d            = 8'd1;
                    end else if (load_use) begin
                        pc_stall_o     = 1'b1;
                        if_id_stall_o  = 1'b1;
                        id_ex_bubble_o = 1'b1;
                    end
                end
                StMduWait: begin
                    if (mdu_done_i) begin
                        state_d = StRun;
                        wd_d    = 8'd0;
                    end else if (wd_q == WdLast) begin
                        timeout_d = 1'b1;
                        state_d   = StRun;
                        wd_d      = 8'd0;
                    end else begin
                        pc_stall_o      = 1'b1;
                        if_id_stall_o   = 1'b1;
                        id_ex_stall_o   = 1'b1;
                        ex_mem_bubble_o = 1'b1;
                        wd_d            = wd_q + 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            wd_q          <= 8'd0;
            mdu_timeout_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_q          <= wd_d;
            mdu_timeout_o <= timeout_d;
        end
    end

    hazard_ctrl_unit_sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (pc_stall_o),
        .count(stall_cnt_o)
    );

    hazard_ctrl_unit_sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (if_id_flush_o),
        .count(flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomised scoreboard bench for hazard_ctrl_unit with a small counter width so
// saturation is reachable.
module tb_hazard_ctrl_unit;

    localparam int unsigned MaxCyc = 40;
    localparam int unsigned CntW   = 6;
    localparam int          CntMax = 63;

    typedef logic [7+2*CntW-1:0] obs_t;

    logic            clk;
    logic            rst_n;
    logic [4:0]      rs1, rs2, rd;
    logic            u1, u2, mr, redir, mdu, done;
    logic            pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble;
    logic            timeout;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    hazard_ctrl_unit #(
        .MDU_MAX_CYCLES(MaxCyc),
        .CNT_W         (CntW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_addr_i  (rs1),
        .id_rs2_addr_i  (rs2),
        .id_uses_rs1_i  (u1),
        .id_uses_rs2_i  (u2),
        .ex_rd_addr_i   (rd),
        .ex_mem_read_i  (mr),
        .ex_redirect_i  (redir),
        .ex_mdu_op_i    (mdu),
        .mdu_done_i     (done),
        .pc_stall_o     (pc_stall),
        .if_id_stall_o  (if_id_stall),
        .if_id_flush_o  (if_id_flush),
        .id_ex_stall_o  (id_ex_stall),
        .id_ex_bubble_o (id_ex_bubble),
        .ex_mem_bubble_o(ex_mem_bubble),
        .mdu_timeout_o  (timeout),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc_no = 0;

    // Reference model: whether an MDU op is holding the pipe and for how many
    // stall cycles so far, the sticky timeout, and plain integer event tallies.
    bit m_busy    = 0;
    int m_stalled = 0;
    bit m_to      = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    task automatic predict();
        bit ps = 0, is = 0, fl = 0, ies = 0, ieb = 0, meb = 0, fire_to = 0, lu;
        if (!rst_n) begin
            m_busy = 0; m_stalled = 0; m_to = 0; m_stall = 0; m_flush = 0;
            exp_q.push_back('0);
            return;
        end
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (!m_busy) begin
            if (redir) begin
                fl = 1; ieb = 1;
            end else if (mdu && !done) begin
                ps = 1; is = 1; ies = 1; meb = 1;
                m_busy = 1; m_stalled = 1;
            end else if (lu) begin
                ps = 1; is = 1; ieb = 1;
            end
        end else if (done) begin
            m_busy = 0;
        end else if (m_stalled == MaxCyc - 1) begin
            fire_to = 1; m_busy = 0;
        end else begin
            ps = 1; is = 1; ies = 1; meb = 1;
            m_stalled++;
        end
        exp_q.push_back({ps, is, fl, ies, ieb, meb, m_to, CntW'(m_stall), CntW'(m_flush)});
        if (fire_to) m_to = 1;
        if (ps && m_stall < CntMax) m_stall++;
        if (fl && m_flush < CntMax) m_flush++;
    endtask

    task automatic drive(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                         input logic b1, input logic b2, input logic [4:0] d, input logic ld,
                         input logic rdr, input logic op, input logic dn);
        @(posedge clk);
        #1;
        rst_n = rst; rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = d;
        mr = ld; redir = rdr; mdu = op; done = dn;
        predict();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble,
                 timeout, stall_cnt, flush_cnt};
            checks++;
            if (a === e) passes++;
            else $display("FAIL outputs cycle %0d: got %b want %b", cyc_no, a, e);
            checks++;
            if (!((if_id_stall && if_id_flush) || (id_ex_stall && id_ex_bubble))) passes++;
            else $display("FAIL invariant cycle %0d: got stall/flush overlap %b want none",
                          cyc_no, a);
            cyc_no++;
        end
    end

    initial begin
        rst_n = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0;
        mr = 0; redir = 0; mdu = 0; done = 0;
        // Reset with a live load-use pattern on the inputs.
        drive(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        drive(1, 5, 0, 1, 0, 5, 1, 0, 0, 0);      // load-use
        idle(1);
        drive(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);      // x0 load
        drive(1, 0, 7, 0, 1, 7, 1, 1, 0, 0);      // redirect beats load-use
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);      // op with same-cycle done
        for (int i = 0; i < 33; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);      // done after 33 stall cycles
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);      // timeout: done never arrives
        for (int i = 0; i < MaxCyc + 2; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 3, 0, 1, 0, 3, 1, 0, 0, 0);      // back in run: load-use still honoured
        for (int i = 0; i < 600; i++) begin
            drive(1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0));
        end
        idle(2);
        // Reset lands in cycle 10 of an MDU wait.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        drive(1, 9, 0, 1, 0, 9, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
